// File: rtl/layer_sequencer_pkg.sv
// Shared FSM encoding and width helpers for the layer sequencer and its capture block.
package layer_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_STREAM,
      S_WAIT,
      S_DRAIN,
      S_FINISH
   } state_t;

   localparam int IN_NUM_DEF      = 784;
   localparam int NEURON_NUM_DEF  = 30;
   localparam int DATA_WIDTH_DEF  = 16;
   localparam int TIMEOUT_CYC_DEF = 64;

   // Never returns 0 so single-entry configurations still get a 1-bit address.
   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // The WAIT counter runs 0..timeout-1.
   function automatic int wait_cnt_w(input int timeout);
      return addr_w(timeout);
   endfunction

endpackage

// File: rtl/layer_sequencer_output_capture.sv
// Per-neuron sticky capture: the first output_valid pulse of each neuron latches its value.
module output_capture
   import layer_seq_pkg::*;
#(
   parameter int NEURON_NUM = NEURON_NUM_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int NW         = addr_w(NEURON_NUM)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             i_cap_en,
   input  logic                             i_clear,
   input  logic [NEURON_NUM-1:0]            i_valid,
   input  logic [NEURON_NUM*DATA_WIDTH-1:0] i_data,
   input  logic [NW-1:0]                    i_rd_addr,
   output logic                             o_all_captured,
   output logic [DATA_WIDTH-1:0]            o_rd_data
);

   logic [NEURON_NUM-1:0] r_mask;
   logic [NEURON_NUM-1:0] w_set;
   logic [DATA_WIDTH-1:0] r_cap [NEURON_NUM];

   assign w_set = i_cap_en ? (i_valid & ~r_mask) : '0;

   // Looks at this cycle's pulses too, so the FSM can leave WAIT right after the last one.
   assign o_all_captured = &(r_mask | w_set);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mask <= '0;
         for (int i = 0; i < NEURON_NUM; i++) begin
            r_cap[i] <= '0;
         end
      end else begin
         if (i_clear) begin
            r_mask <= '0;
         end else begin
            r_mask <= r_mask | w_set;
         end
         for (int i = 0; i < NEURON_NUM; i++) begin
            if (w_set[i]) begin
               r_cap[i] <= i_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   // Uncaptured neurons read as 0 so stale values from an earlier frame never leak out.
   always_comb begin
      o_rd_data = '0;
      for (int i = 0; i < NEURON_NUM; i++) begin
         if (i_rd_addr == NW'(i) && r_mask[i]) begin
            o_rd_data = r_cap[i];
         end
      end
   end

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: streams one input vector to a layer of neurons, gathers their outputs
// and drains them to the next layer's buffer. Optional argmax tracker: LAYER_SEQ_ARGMAX_EN.
module layer_sequencer
   import layer_seq_pkg::*;
#(
   parameter int IN_NUM      = IN_NUM_DEF,
   parameter int NEURON_NUM  = NEURON_NUM_DEF,
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   output logic                             busy,
   output logic                             done,
   output logic                             err,
   output logic                             in_rd_en,
   output logic [addr_w(IN_NUM)-1:0]        in_rd_addr,
   input  logic [DATA_WIDTH-1:0]            in_rd_data,
   output logic [DATA_WIDTH-1:0]            nrn_data,
   output logic                             nrn_valid,
   input  logic [NEURON_NUM-1:0]            nrn_out_valid,
   input  logic [NEURON_NUM*DATA_WIDTH-1:0] nrn_out_data,
   output logic                             out_wr_en,
   output logic [addr_w(NEURON_NUM)-1:0]    out_wr_addr,
   output logic [DATA_WIDTH-1:0]            out_wr_data,
   output logic [addr_w(NEURON_NUM)-1:0]    argmax_idx
);

   localparam int AW = addr_w(IN_NUM);
   localparam int NW = addr_w(NEURON_NUM);
   localparam int CW = wait_cnt_w(TIMEOUT_CYC);
   localparam logic [AW-1:0] LAST_RD   = AW'(IN_NUM - 1);
   localparam logic [NW-1:0] LAST_WR   = NW'(NEURON_NUM - 1);
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYC - 1);

   state_t                r_state;
   logic [CW-1:0]         r_wait_cnt;
   logic                  w_cap_en;
   logic                  w_clear;
   logic                  w_all_captured;
   logic [DATA_WIDTH-1:0] w_rd_data;

   assign nrn_data    = in_rd_data;
   assign out_wr_data = w_rd_data;

   // Short neurons may answer as early as the final STREAM cycle.
   assign w_cap_en = (r_state == S_WAIT) || (r_state == S_STREAM && in_rd_addr == LAST_RD);
   assign w_clear  = (r_state == S_FINISH);

   output_capture #(
      .NEURON_NUM (NEURON_NUM),
      .DATA_WIDTH (DATA_WIDTH),
      .NW         (NW)
   ) u_capture (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_cap_en       (w_cap_en),
      .i_clear        (w_clear),
      .i_valid        (nrn_out_valid),
      .i_data         (nrn_out_data),
      .i_rd_addr      (out_wr_addr),
      .o_all_captured (w_all_captured),
      .o_rd_data      (w_rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_wait_cnt  <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         in_rd_en    <= 1'b0;
         in_rd_addr  <= '0;
         nrn_valid   <= 1'b0;
         out_wr_en   <= 1'b0;
         out_wr_addr <= '0;
      end else begin
         done      <= 1'b0;
         nrn_valid <= in_rd_en;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state    <= S_STREAM;
                  busy       <= 1'b1;
                  err        <= 1'b0;
                  in_rd_en   <= 1'b1;
                  in_rd_addr <= '0;
               end
            end
            S_STREAM: begin
               if (in_rd_addr == LAST_RD) begin
                  r_state    <= S_WAIT;
                  in_rd_en   <= 1'b0;
                  r_wait_cnt <= '0;
               end else begin
                  in_rd_addr <= in_rd_addr + AW'(1);
               end
            end
            S_WAIT: begin
               // A full mask wins over a timeout landing on the same cycle.
               if (w_all_captured || r_wait_cnt == LAST_WAIT) begin
                  r_state     <= S_DRAIN;
                  err         <= ~w_all_captured;
                  out_wr_en   <= 1'b1;
                  out_wr_addr <= '0;
               end else begin
                  r_wait_cnt <= r_wait_cnt + CW'(1);
               end
            end
            S_DRAIN: begin
               if (out_wr_addr == LAST_WR) begin
                  r_state   <= S_FINISH;
                  out_wr_en <= 1'b0;
               end else begin
                  out_wr_addr <= out_wr_addr + NW'(1);
               end
            end
            S_FINISH: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
               done    <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef LAYER_SEQ_ARGMAX_EN
   logic signed [DATA_WIDTH-1:0] r_max_val;
   logic [NW-1:0]                r_max_idx;
   logic [NW-1:0]                r_argmax;

   // Strict compare keeps the lowest index on ties; published together with done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_max_val <= '0;
         r_max_idx <= '0;
         r_argmax  <= '0;
      end else begin
         if (r_state == S_DRAIN) begin
            if (out_wr_addr == '0 || $signed(w_rd_data) > r_max_val) begin
               r_max_val <= $signed(w_rd_data);
               r_max_idx <= out_wr_addr;
            end
         end
         if (r_state == S_FINISH) begin
            r_argmax <= r_max_idx;
         end
      end
   end

   assign argmax_idx = r_argmax;
`else
   assign argmax_idx = '0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with a frame-level timing model and per-cycle compare.
module tb_layer_sequencer;

   localparam int IN_NUM = 4;
   localparam int NN     = 3;
   localparam int DW     = 16;
   localparam int TO     = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          busy, done, err, in_rd_en, nrn_valid, out_wr_en;
   logic [1:0]    in_rd_addr, out_wr_addr, argmax_idx;
   logic [DW-1:0] in_rd_data = '0;
   logic [DW-1:0] nrn_data, out_wr_data;
   logic [NN-1:0] nrn_out_valid = '0;
   logic [NN*DW-1:0] nrn_out_data = '0;

   layer_sequencer #(
      .IN_NUM(IN_NUM), .NEURON_NUM(NN), .DATA_WIDTH(DW), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
      .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
      .nrn_data(nrn_data), .nrn_valid(nrn_valid),
      .nrn_out_valid(nrn_out_valid), .nrn_out_data(nrn_out_data),
      .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
      .argmax_idx(argmax_idx)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scenario: input buffer contents and per-neuron pulse schedule (WAIT-cycle index, -1 = never).
   logic [DW-1:0] ibuf [IN_NUM];
   int            wk [NN];
   int            w2 [NN];
   logic [DW-1:0] val [NN];
   logic [DW-1:0] val2 [NN];

   task automatic set_sched(input int a, input int b, input int c,
                            input logic [DW-1:0] v0, input logic [DW-1:0] v1, input logic [DW-1:0] v2);
      wk = '{a, b, c};
      val = '{v0, v1, v2};
      w2 = '{-1, -1, -1};
      val2 = '{16'h0, 16'h0, 16'h0};
   endtask

   // Input buffer with one-cycle read latency.
   initial begin : buffer_model
      logic          s_en;
      logic [1:0]    s_addr;
      forever begin
         @(negedge clk);
         s_en = in_rd_en;
         s_addr = in_rd_addr;
         @(posedge clk);
         #1;
         in_rd_data = (s_en === 1'b1) ? ibuf[s_addr] : 16'h0;
      end
   end

   // Frame model state.
   bit            have_frame = 0;
   bit            to_f = 0;
   bit            err_prev = 0;
   int            s_f, w_f, d0_f, done_f, frame_arg, exp_arg = 0;
   logic [DW-1:0] expd [NN];
   logic [DW-1:0] m_buf [IN_NUM];
   int            m_wk [NN];
   int            m_w2 [NN];
   logic [DW-1:0] m_val [NN];
   logic [DW-1:0] m_val2 [NN];

   // Observations for the literal checks.
   logic [DW-1:0] obs_wr [NN];
   int            first_wr = -1;
   int            nv_cnt = 0;

   initial begin : compare
      int c, tmax;
      bit e_busy, e_done, e_rd, e_nv, e_wr, e_err, v;
      int e_arg;
      logic [DW-1:0] d;
      forever begin
         @(negedge clk);
         c = cyc;
         if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
            chk("rst_rd_en", in_rd_en, 0);
            chk("rst_rd_addr", in_rd_addr, 0);
            chk("rst_nrn_valid", nrn_valid, 0);
            chk("rst_wr_en", out_wr_en, 0);
            chk("rst_wr_addr", out_wr_addr, 0);
            chk("rst_wr_data", out_wr_data, 0);
            chk("rst_argmax", argmax_idx, 0);
            have_frame = 0;
            err_prev = 0;
            exp_arg = 0;
            nrn_out_valid = '0;
            nrn_out_data = '0;
         end else begin
            e_busy = have_frame && c >= s_f + 1 && c < done_f;
            e_done = have_frame && c == done_f;
            e_rd   = have_frame && c >= s_f + 1 && c <= s_f + IN_NUM;
            e_nv   = have_frame && c >= s_f + 2 && c <= s_f + IN_NUM + 1;
            e_wr   = have_frame && c >= d0_f && c < d0_f + NN;
            e_err  = (have_frame && c >= s_f + 1) ? (to_f && c >= d0_f) : err_prev;
            e_arg  = (have_frame && c >= done_f) ? frame_arg : exp_arg;
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("err", err, e_err);
            chk("in_rd_en", in_rd_en, e_rd);
            if (e_rd) chk("in_rd_addr", in_rd_addr, c - s_f - 1);
            chk("nrn_valid", nrn_valid, e_nv);
            if (e_nv) chk("nrn_data", nrn_data, m_buf[c - s_f - 2]);
            chk("out_wr_en", out_wr_en, e_wr);
            if (e_wr) begin
               chk("out_wr_addr", out_wr_addr, c - d0_f);
               chk("out_wr_data", out_wr_data, expd[c - d0_f]);
            end
            chk("argmax_idx", argmax_idx, e_arg);

            if (out_wr_en === 1'b1 && out_wr_addr < 2'(NN)) begin
               obs_wr[out_wr_addr] = out_wr_data;
               if (out_wr_addr == 2'd0 && first_wr < 0) first_wr = c;
            end
            if (nrn_valid === 1'b1) nv_cnt++;

            if (start && (!have_frame || c >= done_f)) begin
               err_prev = e_err;
               exp_arg = e_arg;
               have_frame = 1;
               s_f = c;
               m_buf = ibuf;
               m_wk = wk;
               m_w2 = w2;
               m_val = val;
               m_val2 = val2;
               to_f = 0;
               tmax = 0;
               for (int i = 0; i < NN; i++) begin
                  if (m_wk[i] < 0) to_f = 1;
                  else if (m_wk[i] > tmax) tmax = m_wk[i];
               end
               w_f = to_f ? TO : ((tmax < 1) ? 1 : tmax);
               if (w_f > TO) begin
                  w_f = TO;
                  to_f = 1;
               end
               for (int i = 0; i < NN; i++)
                  expd[i] = (m_wk[i] >= 0 && m_wk[i] <= w_f) ? m_val[i] : 16'h0;
               d0_f = s_f + IN_NUM + w_f + 1;
               done_f = s_f + IN_NUM + w_f + NN + 2;
               frame_arg = 0;
`ifdef LAYER_SEQ_ARGMAX_EN
               for (int i = 1; i < NN; i++)
                  if ($signed(expd[i]) > $signed(expd[frame_arg])) frame_arg = i;
`endif
               for (int i = 0; i < NN; i++) obs_wr[i] = 16'hEEEE;
               first_wr = -1;
               nv_cnt = 0;
            end

            for (int i = 0; i < NN; i++) begin
               v = 1'b0;
               d = 16'hBAD0 + 16'(i);
               if (have_frame && m_wk[i] >= 0 && c == s_f + IN_NUM + m_wk[i]) begin
                  v = 1'b1;
                  d = m_val[i];
               end else if (have_frame && m_w2[i] >= 0 && c == s_f + IN_NUM + m_w2[i]) begin
                  v = 1'b1;
                  d = m_val2[i];
               end
               nrn_out_valid[i] = v;
               nrn_out_data[i*DW +: DW] = d;
            end
         end
      end
   end

   task automatic pulse_start(output int sc);
      @(posedge clk);
      #1;
      start = 1'b1;
      sc = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int dc);
      dc = -1;
      for (int n = 0; n < 200 && dc < 0; n++) begin
         @(negedge clk);
         if (done === 1'b1) dc = cyc;
      end
      if (dc < 0) begin
         n_assert++;
         n_fail++;
         $display("FAIL done_wait: no done pulse within 200 cycles");
      end
   endtask

   task automatic wait_rd_addr2(output bit ok);
      ok = 0;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         if (in_rd_en === 1'b1 && in_rd_addr == 2'd2) ok = 1;
      end
      n_assert++;
      if (!ok) begin
         n_fail++;
         $display("FAIL rd_addr2_wait: address 2 never issued within 50 cycles");
      end
   endtask

   task automatic wait_wr(output bit ok);
      ok = 0;
      for (int n = 0; n < 100 && !ok; n++) begin
         @(negedge clk);
         if (out_wr_en === 1'b1) ok = 1;
      end
      n_assert++;
      if (!ok) begin
         n_fail++;
         $display("FAIL wr_wait: no write within 100 cycles");
      end
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int  s, d, d1, d2;
      bit  ok;
      ibuf = '{16'd1, 16'd2, 16'd3, 16'd4};
      set_sched(4, 4, 4, 16'd10, 16'd20, 16'd30);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Basic frame: pulses 3 cycles after the last valid.
      pulse_start(s);
      wait_done(d);
      chk("basic_latency", d - s, 13);
      chk("basic_wr0", obs_wr[0], 16'd10);
      chk("basic_wr1", obs_wr[1], 16'd20);
      chk("basic_wr2", obs_wr[2], 16'd30);
      chk("basic_valid_cycles", nv_cnt, 4);
      chk("basic_err", err, 0);
      repeat (3) @(posedge clk);

      // Staggered outputs at WAIT cycles 1, 5, 2; a repeat pulse from neuron 0 is ignored.
      ibuf = '{16'd5, 16'd6, 16'd7, 16'd8};
      set_sched(1, 5, 2, 16'd100, 16'hFF38, 16'd300);
      w2[0] = 3;
      val2[0] = 16'd999;
      pulse_start(s);
      wait_done(d);
      chk("stag_first_write", first_wr - s, 10);
      chk("stag_latency", d - s, 14);
      chk("stag_wr0_first_kept", obs_wr[0], 16'd100);
      chk("stag_wr1", obs_wr[1], 16'hFF38);
      chk("stag_wr2", obs_wr[2], 16'd300);
      repeat (2) @(posedge clk);

      // Timeout: neuron 1 never answers.
      set_sched(2, -1, 3, 16'd11, 16'd22, 16'd33);
      pulse_start(s);
      wait_done(d);
      chk("to_latency", d - s, 17);
      chk("to_first_write", first_wr - s, 13);
      chk("to_err", err, 1);
      chk("to_wr0", obs_wr[0], 16'd11);
      chk("to_wr1_zero", obs_wr[1], 16'd0);
      chk("to_wr2", obs_wr[2], 16'd33);
      repeat (2) @(posedge clk);

      // Start held high: timed-out frame, then one new frame accepted at done.
      set_sched(1, -1, 1, 16'd1, 16'd2, 16'd3);
      @(posedge clk);
      #1;
      start = 1'b1;
      s = cyc;
      wait_wr(ok);
      set_sched(0, 1, 1, 16'd40, 16'd50, 16'd60);
      wait_done(d1);
      chk("held_latency1", d1 - s, 17);
      chk("held_err_at_done", err, 1);
      @(negedge clk);
      chk("held_err_cleared", err, 0);
      chk("held_busy_again", busy, 1);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(d2);
      chk("held_latency2", d2 - d1, 10);
      chk("held_wr0_stream_capture", obs_wr[0], 16'd40);
      chk("held_err2", err, 0);
      repeat (3) @(posedge clk);

      // Reset while address 2 is being read.
      ibuf = '{16'd9, 16'd8, 16'd7, 16'd6};
      set_sched(3, 3, 3, 16'd7, 16'd8, 16'd9);
      pulse_start(s);
      wait_rd_addr2(ok);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid_busy", busy, 0);
      chk("rstmid_rd_en", in_rd_en, 0);
      chk("rstmid_rd_addr", in_rd_addr, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      pulse_start(s);
      wait_done(d);
      chk("rstmid_latency", d - s, 12);
      chk("rstmid_wr0", obs_wr[0], 16'd7);
      chk("rstmid_wr2", obs_wr[2], 16'd9);
      repeat (2) @(posedge clk);

      // Argmax with a negative value and a tie.
      set_sched(2, 2, 2, 16'hFFFB, 16'd7, 16'd7);
      pulse_start(s);
      wait_done(d);
      chk("argmax_latency", d - s, 11);
`ifdef LAYER_SEQ_ARGMAX_EN
      chk("argmax_at_done", argmax_idx, 1);
`else
      chk("argmax_at_done", argmax_idx, 0);
`endif
      repeat (4) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Controls one fully-connected layer of neuron instances.
- Per frame it streams the input vector from an input buffer to all neurons in parallel and collects every neuron's one-cycle output pulse.
- It then writes the layer's outputs into the next layer's input buffer, one word per cycle.
- One instance sits between each pair of layer buffers; the top-level chains instances through start/done.

Parameters:
IN_NUM, 784, input vector length; equals each neuron's weight count
NEURON_NUM, 30, number of neurons in the layer
DATA_WIDTH, 16, data word width
TIMEOUT_CYC, 64, max cycles in WAIT before flagging an error

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  frame request; sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at frame end
err  out  1  sticky timeout flag; cleared by the next accepted start
in_rd_en  out  1  input buffer read enable
in_rd_addr  out  clog2(IN_NUM)  input buffer read address
in_rd_data  in  DATA_WIDTH  input buffer data; one-cycle read latency
nrn_data  out  DATA_WIDTH  broadcast neuron input; combinational copy of in_rd_data
nrn_valid  out  1  broadcast neuron input_valid; in_rd_en delayed one cycle
nrn_out_valid  in  NEURON_NUM  per-neuron output_valid pulses
nrn_out_data  in  NEURON_NUM*DATA_WIDTH  per-neuron outputs; neuron i in slice i
out_wr_en  out  1  output buffer write enable
out_wr_addr  out  clog2(NEURON_NUM)  output buffer write address
out_wr_data  out  DATA_WIDTH  output buffer write data
argmax_idx  out  clog2(NEURON_NUM)  index of the largest output; see Optional Feature

Behaviour:
- Reset: all outputs 0. State is IDLE; counters, capture mask and capture registers are cleared.
- FSM states: IDLE, STREAM, WAIT, DRAIN, FINISH.
- IDLE:
  - start=1 moves to STREAM next cycle and clears err.
  - start is ignored in every other state; there is no queueing.
- STREAM:
  - in_rd_en=1 for exactly IN_NUM consecutive cycles, with in_rd_addr 0..IN_NUM-1.
  - The cycle that issues address IN_NUM-1 is the last STREAM cycle; the FSM then moves to WAIT.
  - nrn_valid therefore runs IN_NUM cycles, starting one cycle after the first in_rd_en.
  - There are no gaps: the neuron accumulator depends on a contiguous valid run.
- WAIT:
  - Each rising bit of nrn_out_valid sets mask[i] and latches slice i of nrn_out_data into cap[i].
  - Capture is also active in the final STREAM cycle, in case the neurons are short.
  - Once mask is all ones, the FSM moves to DRAIN on the next cycle.
  - A saturating counter counts WAIT cycles. When it reaches TIMEOUT_CYC, err is set and the FSM moves to DRAIN. Missing entries are written as 0.
  - A second pulse from an already-captured neuron is ignored; the first value is kept.
- DRAIN:
  - out_wr_en=1 for NEURON_NUM cycles, with out_wr_addr 0..NEURON_NUM-1 and out_wr_data=cap[addr].
  - It then moves to FINISH.
- FINISH:
  - One cycle long: done=1, mask cleared, then return to IDLE.
  - busy falls in the same cycle that done is high.
- Latency: start at cycle 0 gives the first in_rd_en at cycle 1. done comes at cycle 1 + IN_NUM + W + NEURON_NUM + 1, where W is the number of WAIT cycles.
- Reset mid-frame: everything returns to IDLE immediately. No done pulse and no partial writes after reset.
- Neurons clear their address counter on output_valid. The sequencer therefore never starts a new STREAM before all outputs are captured or the timeout has fired.
- Edge case IN_NUM=1: STREAM lasts a single cycle.

Optional Feature:
- Macro: LAYER_SEQ_ARGMAX_EN.
- Defined:
  - During DRAIN a signed running maximum over cap[] is tracked.
  - Ties keep the lowest index.
  - argmax_idx updates at done and holds until the next done.
- Undefined: no comparator is built and argmax_idx is constant 0.

Decomposition:
- Package layer_seq_pkg holds:
  - the FSM state encoding;
  - the helper widths: address width as clog2(IN_NUM), clog2(NEURON_NUM), and the WAIT counter width.
- Sub-module output_capture holds the per-neuron sticky mask and data latches. Its outputs are all_captured and the indexed read port cap[out_wr_addr].

Test Plan:
- Basic frame:
  - Stimulus: IN_NUM=4, NEURON_NUM=3; buffer holds 1,2,3,4; neuron models pulse 3 cycles after the last valid with outputs 10,20,30.
  - Expected: reads at addresses 0-3 on consecutive cycles; nrn_valid high exactly 4 cycles; writes addr0=10, addr1=20, addr2=30; one done pulse; err=0.
- Staggered outputs:
  - Stimulus: neurons pulse at WAIT cycles 1, 5 and 2.
  - Expected: DRAIN starts the cycle after the pulse at cycle 5; writes are in index order.
- Timeout:
  - Stimulus: neuron 1 never pulses; TIMEOUT_CYC=8.
  - Expected: err=1 after 8 WAIT cycles; addr1 is written as 0; done still pulses.
- Start while busy:
  - Stimulus: start held high throughout.
  - Expected: only a new frame after done; err cleared at the new start.
- Reset mid-STREAM:
  - Stimulus: rst_n low at address 2.
  - Expected: all outputs 0 immediately; no writes; a fresh start streams from address 0.
- Argmax (LAYER_SEQ_ARGMAX_EN defined):
  - Stimulus: outputs -5, 7, 7.
  - Expected: argmax_idx=1 at done.
  - With the macro undefined: argmax_idx=0.
